// File: rtl/instr_mem_prog_if.sv
// Program and fetch bus between the PC/fetch stage, the loader and instr_mem_prog.
// master drives requests and program writes; slave is the memory.
interface instr_mem_prog_if #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 16
);
    logic              prog_en;
    logic              prog_we;
    logic [ADDR_W-1:0] prog_addr;
    logic [DATA_W-1:0] prog_data;
    logic              fetch_req;
    logic [ADDR_W-1:0] fetch_pc;
    logic              fetch_ready;
    logic              stall;
    logic [DATA_W-1:0] instr;
    logic [ADDR_W-1:0] instr_pc;
    logic              instr_valid;
    logic              fault_range;
    logic              fault_align;
    logic              fault_sticky;
    logic [1:0]        mode;

    modport master (
        output prog_en, prog_we, prog_addr, prog_data,
        output fetch_req, fetch_pc, stall,
        input  fetch_ready, instr, instr_pc, instr_valid,
        input  fault_range, fault_align, fault_sticky, mode
    );

    modport slave (
        input  prog_en, prog_we, prog_addr, prog_data,
        input  fetch_req, fetch_pc, stall,
        output fetch_ready, instr, instr_pc, instr_valid,
        output fault_range, fault_align, fault_sticky, mode
    );
endinterface

// File: rtl/instr_mem_prog.sv
// Programmable instruction memory: swept to NOP after reset, written in LOAD,
// read in RUN through a registered fetch port with stall hold and fault flags.
module instr_mem_prog #(
    parameter int unsigned       DATA_W = 16,
    parameter int unsigned       ADDR_W = 16,
    parameter int unsigned       DEPTH  = 16,
    parameter logic [DATA_W-1:0] NOP    = '0
) (
    input logic             clk,
    input logic             rst_n,
    instr_mem_prog_if.slave bus
);
    localparam int unsigned       SH         = $clog2(DATA_W / 8);
    localparam int unsigned       IDX_W      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'((1 << SH) - 1);
    localparam logic [ADDR_W:0]   DEPTH_X    = (ADDR_W + 1)'(DEPTH);
    localparam logic [IDX_W-1:0]  LAST_IDX   = IDX_W'(DEPTH - 1);

    typedef enum logic [1:0] {
        CLEAR = 2'b00,
        LOAD  = 2'b01,
        RUN   = 2'b10
    } state_t;

    state_t            state;
    logic [IDX_W-1:0]  sweep;
    logic [DATA_W-1:0] mem [DEPTH];

    logic [ADDR_W-1:0] prog_idx;
    logic [ADDR_W-1:0] fetch_idx;
    logic              prog_ok;
    logic              fetch_in_range;
    logic              fetch_aligned;
    logic              fetch_accept;

    logic              mem_we;
    logic [IDX_W-1:0]  mem_widx;
    logic [DATA_W-1:0] mem_wdata;

    // Range is judged on the full-width index so high PCs never alias low words.
    assign prog_idx       = bus.prog_addr >> SH;
    assign fetch_idx      = bus.fetch_pc >> SH;
    assign prog_ok        = ({1'b0, prog_idx} < DEPTH_X) && ((bus.prog_addr & ALIGN_MASK) == '0);
    assign fetch_in_range = {1'b0, fetch_idx} < DEPTH_X;
    assign fetch_aligned  = (bus.fetch_pc & ALIGN_MASK) == '0;
    assign fetch_accept   = (state == RUN) && bus.fetch_req && !bus.stall;

    assign bus.fetch_ready = (state == RUN) && !bus.stall;
    assign bus.mode        = state;

    always_comb begin
        mem_we    = 1'b0;
        mem_widx  = sweep;
        mem_wdata = NOP;
        case (state)
            CLEAR: mem_we = 1'b1;
            LOAD: begin
                mem_we    = bus.prog_we && prog_ok;
                mem_widx  = prog_idx[IDX_W-1:0];
                mem_wdata = bus.prog_data;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_widx] <= mem_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= CLEAR;
            sweep            <= '0;
            bus.instr        <= NOP;
            bus.instr_pc     <= '0;
            bus.instr_valid  <= 1'b0;
            bus.fault_range  <= 1'b0;
            bus.fault_align  <= 1'b0;
            bus.fault_sticky <= 1'b0;
        end else begin
            case (state)
                CLEAR: begin
                    sweep <= sweep + IDX_W'(1);
                    if (sweep == LAST_IDX) begin
                        if (bus.prog_en) begin
                            state            <= LOAD;
                            bus.fault_sticky <= 1'b0;
                            bus.instr_valid  <= 1'b0;
                        end else begin
                            state <= RUN;
                        end
                    end
                end
                LOAD: begin
                    if (!bus.prog_en) begin
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (fetch_accept) begin
                        bus.instr       <= (fetch_aligned && fetch_in_range) ?
                                           mem[fetch_idx[IDX_W-1:0]] : NOP;
                        bus.instr_pc    <= bus.fetch_pc;
                        bus.instr_valid <= 1'b1;
                        bus.fault_range <= !fetch_in_range;
                        bus.fault_align <= !fetch_aligned;
                        if (!fetch_in_range || !fetch_aligned) begin
                            bus.fault_sticky <= 1'b1;
                        end
                    end else if (!bus.stall) begin
                        bus.instr_valid <= 1'b0;
                    end
                    // A fetch accepted on the LOAD-entry edge is registered but
                    // invalidated here, since these later assignments win.
                    if (bus.prog_en) begin
                        state            <= LOAD;
                        bus.instr_valid  <= 1'b0;
                        bus.fault_sticky <= 1'b0;
                    end
                end
                default: state <= CLEAR;
            endcase
        end
    end
endmodule

// File: tb/tb_instr_mem_prog.sv
// Bench for instr_mem_prog: table of fetch vectors fed through a scoreboard,
// plus hand-written sequences for reset, LOAD, stall and mid-RUN reset.
module tb_instr_mem_prog;
    localparam int unsigned DATA_W = 16;
    localparam int unsigned ADDR_W = 16;
    localparam int unsigned DEPTH  = 16;
    localparam logic [15:0] NOP    = 16'h0000;

    typedef struct {
        logic [15:0] pc;
        logic [15:0] instr;
        logic        fr;
        logic        fa;
    } fetch_vec_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       push_now = 1'b0;
    logic       acc_q = 1'b0;
    int         checks = 0;
    int         errors = 0;
    fetch_vec_t sb[$];
    fetch_vec_t vecs[10];

    always #5 clk = ~clk;

    instr_mem_prog_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    instr_mem_prog #(
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W),
        .DEPTH (DEPTH),
        .NOP   (NOP)
    ) u_dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Result of a fetch accepted on the previous edge is due now.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) acc_q <= 1'b0;
        else        acc_q <= push_now;
    end

    always @(negedge clk) begin
        if (acc_q) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_underflow: got output with empty scoreboard at %0t", $time);
            end else begin
                fetch_vec_t e;
                e = sb.pop_front();
                chk("sb_instr",    32'(bus.instr),       32'(e.instr));
                chk("sb_instr_pc", 32'(bus.instr_pc),    32'(e.pc));
                chk("sb_valid",    32'(bus.instr_valid), 32'(1));
                chk("sb_range",    32'(bus.fault_range), 32'(e.fr));
                chk("sb_align",    32'(bus.fault_align), 32'(e.fa));
            end
        end
    end

    // All tasks start and end at a falling edge.
    task automatic fetch(input logic [15:0] pc, input logic [15:0] ins, input logic fr, input logic fa);
        bus.fetch_req = 1'b1;
        bus.fetch_pc  = pc;
        bus.stall     = 1'b0;
        bus.prog_we   = 1'b0;
        push_now      = 1'b1;
        sb.push_back('{pc, ins, fr, fa});
        @(negedge clk);
    endtask

    task automatic idle();
        bus.fetch_req = 1'b0;
        bus.stall     = 1'b0;
        bus.prog_we   = 1'b0;
        push_now      = 1'b0;
        @(negedge clk);
    endtask

    task automatic write(input logic [15:0] addr, input logic [15:0] data);
        bus.fetch_req = 1'b0;
        bus.prog_we   = 1'b1;
        bus.prog_addr = addr;
        bus.prog_data = data;
        push_now      = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vecs[0] = '{16'h0000, 16'h8080, 1'b0, 1'b0};
        vecs[1] = '{16'h0002, 16'h8101, 1'b0, 1'b0};
        vecs[2] = '{16'h001E, 16'hBEEF, 1'b0, 1'b0};
        vecs[3] = '{16'h0004, 16'h0000, 1'b0, 1'b0};
        vecs[4] = '{16'h0008, 16'h1234, 1'b0, 1'b0};
        vecs[5] = '{16'h0020, NOP,      1'b1, 1'b0};
        vecs[6] = '{16'h0003, NOP,      1'b0, 1'b1};
        vecs[7] = '{16'h001F, NOP,      1'b0, 1'b1};
        vecs[8] = '{16'h0021, NOP,      1'b1, 1'b1};
        vecs[9] = '{16'hFFFE, NOP,      1'b1, 1'b0};

        rst_n         = 1'b0;
        bus.prog_en   = 1'b0;
        bus.prog_we   = 1'b0;
        bus.prog_addr = '0;
        bus.prog_data = '0;
        bus.fetch_req = 1'b0;
        bus.fetch_pc  = '0;
        bus.stall     = 1'b0;
        repeat (3) @(negedge clk);

        chk("rst_instr",   32'(bus.instr),        32'(NOP));
        chk("rst_pc",      32'(bus.instr_pc),     32'(0));
        chk("rst_valid",   32'(bus.instr_valid),  32'(0));
        chk("rst_range",   32'(bus.fault_range),  32'(0));
        chk("rst_align",   32'(bus.fault_align),  32'(0));
        chk("rst_sticky",  32'(bus.fault_sticky), 32'(0));
        chk("rst_mode",    32'(bus.mode),         32'(0));
        chk("rst_ready",   32'(bus.fetch_ready),  32'(0));

        // CLEAR sweep: 15 edges still in CLEAR, RUN after the 16th
        rst_n = 1'b1;
        for (int unsigned i = 0; i < DEPTH - 1; i++) begin
            @(negedge clk);
            chk("clr_mode",  32'(bus.mode),        32'(0));
            chk("clr_ready", 32'(bus.fetch_ready), 32'(0));
        end
        @(negedge clk);
        chk("run_mode",  32'(bus.mode),        32'(2));
        chk("run_ready", 32'(bus.fetch_ready), 32'(1));

        fetch(16'h0006, NOP, 1'b0, 1'b0);
        idle();
        chk("idle_valid", 32'(bus.instr_valid), 32'(0));

        // LOAD: good writes plus two that must be dropped
        bus.prog_en = 1'b1;
        @(negedge clk);
        chk("load_mode",  32'(bus.mode),        32'(1));
        chk("load_ready", 32'(bus.fetch_ready), 32'(0));
        write(16'h0000, 16'h8080);
        write(16'h0002, 16'h8101);
        write(16'h001E, 16'hBEEF);
        write(16'h0008, 16'h1234);
        write(16'h0040, 16'hDEAD);
        write(16'h0005, 16'h5555);
        bus.prog_en = 1'b0;
        bus.prog_we = 1'b0;
        @(negedge clk);
        chk("load_exit_mode", 32'(bus.mode),         32'(2));
        chk("load_sticky",    32'(bus.fault_sticky), 32'(0));

        for (int unsigned i = 0; i < 10; i++) begin
            if (i == 5) chk("sticky_clean", 32'(bus.fault_sticky), 32'(0));
            fetch(vecs[i].pc, vecs[i].instr, vecs[i].fr, vecs[i].fa);
        end
        idle();
        chk("sticky_set", 32'(bus.fault_sticky), 32'(1));

        // Stall holds the previous result for three cycles
        fetch(16'h0002, 16'h8101, 1'b0, 1'b0);
        for (int unsigned k = 0; k < 3; k++) begin
            bus.stall     = 1'b1;
            bus.fetch_req = 1'b1;
            bus.fetch_pc  = (k == 0) ? 16'h0000 : (k == 1) ? 16'h001E : 16'h0020;
            push_now      = 1'b0;
            #1;
            chk("stall_ready", 32'(bus.fetch_ready), 32'(0));
            @(negedge clk);
            chk("stall_instr", 32'(bus.instr),       32'(16'h8101));
            chk("stall_pc",    32'(bus.instr_pc),    32'(16'h0002));
            chk("stall_valid", 32'(bus.instr_valid), 32'(1));
            chk("stall_range", 32'(bus.fault_range), 32'(0));
        end
        fetch(16'h001E, 16'hBEEF, 1'b0, 1'b0);
        idle();

        // Re-entering LOAD drops a same-cycle fetch and clears sticky
        chk("sticky_before_load", 32'(bus.fault_sticky), 32'(1));
        bus.prog_en   = 1'b1;
        bus.fetch_req = 1'b1;
        bus.fetch_pc  = 16'h0000;
        push_now      = 1'b0;
        #1;
        chk("reload_ready", 32'(bus.fetch_ready), 32'(1));
        @(negedge clk);
        chk("reload_mode",   32'(bus.mode),         32'(1));
        chk("reload_sticky", 32'(bus.fault_sticky), 32'(0));
        chk("reload_valid",  32'(bus.instr_valid),  32'(0));
        bus.prog_en   = 1'b0;
        bus.fetch_req = 1'b0;
        @(negedge clk);
        chk("reload_exit_mode", 32'(bus.mode), 32'(2));

        // Asynchronous reset between edges while holding a valid result
        fetch(16'h0020, NOP, 1'b1, 1'b0);
        fetch(16'h0002, 16'h8101, 1'b0, 1'b0);
        bus.fetch_req = 1'b0;
        bus.stall     = 1'b1;
        push_now      = 1'b0;
        @(posedge clk);
        #2;
        rst_n     = 1'b0;
        bus.stall = 1'b0;
        #1;
        chk("arst_instr",  32'(bus.instr),        32'(NOP));
        chk("arst_pc",     32'(bus.instr_pc),     32'(0));
        chk("arst_valid",  32'(bus.instr_valid),  32'(0));
        chk("arst_range",  32'(bus.fault_range),  32'(0));
        chk("arst_sticky", 32'(bus.fault_sticky), 32'(0));
        chk("arst_mode",   32'(bus.mode),         32'(0));
        chk("arst_ready",  32'(bus.fetch_ready),  32'(0));
        @(negedge clk);
        rst_n = 1'b1;
        repeat (DEPTH - 1) @(negedge clk);
        chk("resweep_mode_clear", 32'(bus.mode), 32'(0));
        @(negedge clk);
        chk("resweep_mode_run", 32'(bus.mode), 32'(2));
        fetch(16'h0000, NOP, 1'b0, 1'b0);
        fetch(16'h0002, NOP, 1'b0, 1'b0);
        idle();
        idle();

        chk("sb_empty", 32'(sb.size()), 32'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/instr_mem_prog.md
# instr_mem_prog

Parametrised, programmable instruction memory for the processor front end. It replaces the fixed 16-entry initialised ROM with a synchronous RAM of configurable width and depth. The RAM is cleared to NOP after reset, loaded through a program port, and read through a registered fetch port with stall handshake and per-fetch fault reporting. It sits between the PC/fetch stage and the decode stage.

## Interface
Parameters:
- DATA_W, 16, instruction width in bits; multiple of 8, DATA_W/8 a power of two
- ADDR_W, 16, PC / program-address width (byte address)
- DEPTH, 16, number of instruction words; power of two, DEPTH*DATA_W/8 <= 2^ADDR_W
- NOP, 0, DATA_W-bit value returned for cleared, out-of-range or misaligned fetches

Derived: SH = log2(DATA_W/8); word index = addr >> SH.

Ports:
- clk  in  1  single clock, all state on rising edge
- rst_n  in  1  reset, asynchronous and active-low
- prog_en  in  1  request program mode
- prog_we  in  1  write strobe, honoured only in LOAD
- prog_addr  in  ADDR_W  byte address of word to write
- prog_data  in  DATA_W  word to write
- fetch_req  in  1  fetch request
- fetch_pc  in  ADDR_W  byte address to fetch
- fetch_ready  out  1  fetch accepted this cycle when fetch_req && fetch_ready
- stall  in  1  decode not accepting; holds fetch output
- instr  out  DATA_W  fetched instruction
- instr_pc  out  ADDR_W  PC of instr
- instr_valid  out  1  instr/instr_pc valid
- fault_range  out  1  current instr came from PC word index >= DEPTH
- fault_align  out  1  current instr came from PC with nonzero low SH bits
- fault_sticky  out  1  OR of all faults since last LOAD entry
- mode  out  2  state: 00 CLEAR, 01 LOAD, 10 RUN

## Operation
- FSM states: CLEAR, LOAD, RUN. Reset forces CLEAR with sweep counter = 0.
- CLEAR: writes NOP to word[counter] each cycle and increments the counter. After word DEPTH-1 is written, goes to LOAD if prog_en is high, otherwise RUN. prog_en, prog_we and fetch_req are ignored.
- LOAD: each cycle with prog_we high writes prog_data to word[prog_addr>>SH]. Writes with index >= DEPTH or misaligned addresses are dropped silently. When prog_en is low, goes to RUN on the next edge. Entering LOAD clears fault_sticky and instr_valid.
- RUN: fetch_ready = !stall. An accepted fetch registers the following for the next cycle:
  - instr = (aligned && index < DEPTH) ? word[index] : NOP
  - instr_pc = fetch_pc
  - fault_range and fault_align per the fetch
  - instr_valid = 1
- RUN, cycle with no accepted fetch and stall low: instr_valid = 0 next cycle; other outputs hold.
- stall high: instr, instr_pc, instr_valid and the fault bits hold.
- RUN with prog_en high: goes to LOAD on the next edge. A fetch presented in that same cycle is still accepted, but its result is discarded because entering LOAD clears instr_valid.
- fault_sticky sets on the edge that registers any fault and stays set until LOAD entry or reset.
- fetch_ready = 0 outside RUN.

## Timing
- Reset values: instr = NOP, instr_pc = 0, instr_valid = 0, fault_range = 0, fault_align = 0, fault_sticky = 0, mode = 00, fetch_ready = 0.
- After rst_n deasserts, CLEAR lasts exactly DEPTH cycles. fetch_ready is first high in cycle DEPTH (0-based, first edge after release = cycle 0), provided prog_en is low.
- Fetch latency: 1 cycle. A fetch accepted at edge N shows on instr at edge N+1.
- Back-to-back fetches sustain 1 per cycle when stall is low.
- A write in LOAD at edge N is visible to a fetch accepted in RUN at any later edge. There is no read/write overlap, since writes only occur in LOAD.
- Reset mid-LOAD or mid-RUN: all outputs return to reset values immediately. Memory contents are destroyed by the CLEAR re-sweep.
- PC wrap: the index is computed on the full ADDR_W. Addresses past DEPTH report fault_range and never alias onto low words.

## Test plan
- Reset release with prog_en=0, DEPTH=16: mode=00 for 16 cycles, then 10. A fetch of PC 0x0006 returns 0x0000 with instr_valid=1 one cycle later.
- Program port: prog_en=1, write 0x8080@0x0000, 0x8101@0x0002, 0xBEEF@0x001E; drop prog_en. Fetches of 0,2,0x1E return 0x8080, 0x8101, 0xBEEF back-to-back, one per cycle.
- Range/alignment: fetch 0x0020 returns NOP with fault_range=1; fetch 0x0003 returns NOP with fault_align=1; fault_sticky=1 afterwards. Re-entering LOAD clears fault_sticky.
- Stall: after the fetch of 0x0002, hold stall=1 for 3 cycles while toggling fetch_pc. instr stays 0x8101, instr_pc stays 0x0002, fetch_ready=0. The next accepted fetch resumes with 1-cycle latency.
- Dropped writes: a LOAD write to 0x0040 or 0x0005 changes no word. Fetching 0x0000 and 0x0004 afterwards returns the prior values.
- Reset mid-RUN: assert rst_n=0 asynchronously between edges. Outputs go to reset values immediately; after the re-sweep, a fetch of 0x0000 returns NOP.
